// File: rtl/arbitre_mux_8bitx2_pkg.sv
// Shared definitions for the two-source arbiters: owner-state encodings,
// source codes and the counter width used for burst tracking.
package arbitre_mux_8bitx2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } arbState_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam int CNT_W = 3;

  // Owner state that corresponds to a given source code.
  function automatic arbState_e ownerState(input logic src);
    return (src == SRC_B) ? OWN_B : OWN_A;
  endfunction

endpackage

// File: rtl/multiplexeur_8bitx2.sv
// 8-bit two-input multiplexer; select uses the shared source codes.
module multiplexeur_8bitx2
  import arbitre_mux_8bitx2_pkg::*;
(
  input  logic       sel,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  assign y = (sel == SRC_B) ? b : a;

endmodule

// File: rtl/arbitre_mux_8bitx2.sv
// Two-source arbiter feeding a single registered output word. A source may
// keep ownership for up to BURST consecutive grants while the other source
// is also requesting; after that the grant alternates.
module arbitre_mux_8bitx2
  import arbitre_mux_8bitx2_pkg::*;
#(
  parameter int BURST = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [7:0] data_a,
  input  logic [7:0] data_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       out_src
);

  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

  arbState_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             outValid_q, outValid_d;
  logic [7:0]       outData_q, outData_d;
  logic             outSrc_q, outSrc_d;

  logic             load;
  logic             stall;
  logic             winner;
  logic [7:0]       muxData;

  // A full register that the consumer is not taking freezes everything.
  assign stall = outValid_q & ~out_ready;
  assign load  = (~outValid_q | out_ready) & (req_a | req_b);

  // Acks are gated by reset so a requester never sees a strobe while held in reset.
  assign ack_a = rst_n & load & (winner == SRC_A);
  assign ack_b = rst_n & load & (winner == SRC_B);

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_src   = outSrc_q;

  multiplexeur_8bitx2 u_mux (
    .sel (winner),
    .a   (data_a),
    .b   (data_b),
    .y   (muxData)
  );

  // Winner: a lone requester wins; on a tie the owner keeps it until its burst is used up, then the other side gets it.
  always_comb begin
    winner = ~last_q;
    if (req_a && !req_b) begin
      winner = SRC_A;
    end else if (req_b && !req_a) begin
      winner = SRC_B;
    end else if (state_q == OWN_A && cnt_q < BURST_C) begin
      winner = SRC_A;
    end else if (state_q == OWN_B && cnt_q < BURST_C) begin
      winner = SRC_B;
    end
  end

  // Ownership, burst count and last-winner update; the count saturates at BURST.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (load) begin
      state_d = ownerState(winner);
      last_d  = winner;
      if (state_q == ownerState(winner)) begin
        cnt_d = (cnt_q >= BURST_C) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cnt_d = 1;
      end
    end else if (!req_a && !req_b && !stall) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Output register: load the selected word, or empty it once it has been taken.
  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outSrc_d   = outSrc_q;
    if (load) begin
      outValid_d = 1'b1;
      outData_d  = muxData;
      outSrc_d   = winner;
    end else if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // State and output registers; reset leaves last = B so A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= SRC_B;
      outValid_q <= 1'b0;
      outData_q  <= 8'd0;
      outSrc_q   <= SRC_A;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outSrc_q   <= outSrc_d;
    end
  end

endmodule
